reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/rv32i_types.sv | 22 ++
 rtl/rob_commit_scan.sv | 30 +++
 rtl/reorder_buffer.sv | 161 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: ROB entry layout and ROB sizing constants.
package rv32i_types;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_ID_W  = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [4:0]  rd_addr;
    logic        trap;
  } rvfi_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] result;
    rvfi_t       rvfi;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_scan.sv
// Thermometer scan of ready entries starting at the ROB head.
module rob_commit_scan #(
  parameter  int DEPTH = 16,
  parameter  int CW    = 2,
  localparam int IDW   = $clog2(DEPTH),
  localparam int NCW   = $clog2(CW + 1)
) (
  input  logic [IDW-1:0]   head_i,
  input  logic [DEPTH-1:0] rdy_i,
  output logic [CW-1:0]    mask_o,
  output logic [NCW-1:0]   cnt_o
);

  logic           run;
  logic [IDW-1:0] idx;

  always_comb begin
    run    = 1'b1;
    idx    = head_i;
    mask_o = '0;
    cnt_o  = '0;
    for (int i = 0; i < CW; i++) begin
      idx       = head_i + IDW'(i);
      run       = run & rdy_i[idx];
      mask_o[i] = run;
      if (run) cnt_o = cnt_o + NCW'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Superscalar reorder buffer with CDB writeback and partial in-order commit.
// Define ROB_FLUSH_EN to build the mispredict rollback path.
module reorder_buffer
  import rv32i_types::*;
#(
  parameter  int SS    = 2,
  parameter  int CW    = 2,
  parameter  int DEPTH = 16,
  parameter  int N_CDB = 3,
  localparam int IDW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SS-1:0]    disp_valid,
  input  rob_entry_t       disp_entry   [SS],
  output logic             disp_ready,
  output logic [IDW-1:0]   disp_rob_id  [SS],
  input  logic [N_CDB-1:0] cdb_valid,
  input  logic [IDW-1:0]   cdb_rob_id   [N_CDB],
  input  logic [31:0]      cdb_result   [N_CDB],
  output logic [CW-1:0]    commit_valid,
  output rob_entry_t       commit_entry [CW],
  output logic [63:0]      commit_order [CW],
  input  logic             flush_valid,
  input  logic [IDW-1:0]   flush_rob_id,
  output logic [IDW:0]     count
);

  localparam int NSW = $clog2(SS + 1);
  localparam int NCW = $clog2(CW + 1);
  localparam logic [IDW:0] RDY_MAX = (IDW+1)'(DEPTH - SS);

  logic [IDW-1:0]   head_q, head_d;
  logic [IDW-1:0]   tail_q, tail_d;
  logic [IDW:0]     count_q, count_d;
  logic [63:0]      order_q, order_d;
  logic [DEPTH-1:0] occ_q, occ_d;
  logic [DEPTH-1:0] done_q, done_d;
  rob_entry_t       ent_q [DEPTH];

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] kill;
  logic [CW-1:0]    cmask;
  logic [NCW-1:0]   ncommit;
  logic [NSW-1:0]   ndisp;
  logic             disp_fire;
  logic             flush_fire;

`ifdef ROB_FLUSH_EN
  logic [IDW-1:0] fage;

  // Age is distance from head; anything older than the flush point survives.
  always_comb begin
    fage = flush_rob_id - head_q;
    kill = '0;
    for (int e = 0; e < DEPTH; e++)
      kill[e] = flush_valid && occ_q[e] && ((IDW'(e) - head_q) > fage);
  end

  assign flush_fire = flush_valid;
`else
  logic unused_flush;

  assign unused_flush = ^{flush_valid, flush_rob_id};
  assign kill         = '0;
  assign flush_fire   = 1'b0;
`endif

  assign count      = count_q;
  assign disp_ready = (count_q <= RDY_MAX);
  assign disp_fire  = disp_ready && (|disp_valid) && !flush_fire;
  assign rdy        = occ_q & done_q & ~kill;

  rob_commit_scan #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_scan (
    .head_i (head_q),
    .rdy_i  (rdy),
    .mask_o (cmask),
    .cnt_o  (ncommit)
  );

  assign commit_valid = cmask;

  always_comb begin
    for (int i = 0; i < SS; i++)
      disp_rob_id[i] = tail_q + IDW'(i);
    for (int i = 0; i < CW; i++) begin
      commit_entry[i] = ent_q[head_q + IDW'(i)];
      commit_order[i] = order_q + 64'(i);
    end
  end

  always_comb begin
    ndisp = '0;
    for (int i = 0; i < SS; i++)
      ndisp = ndisp + NSW'(disp_valid[i]);
  end

  always_comb begin
    head_d  = head_q + IDW'(ncommit);
    order_d = order_q + 64'(ncommit);
    occ_d   = occ_q & ~kill;
    done_d  = done_q & ~kill;
    tail_d  = tail_q;
    count_d = count_q - (IDW+1)'(ncommit);
    for (int j = 0; j < N_CDB; j++)
      if (cdb_valid[j] && occ_q[cdb_rob_id[j]] && !kill[cdb_rob_id[j]])
        done_d[cdb_rob_id[j]] = 1'b1;
    for (int i = 0; i < CW; i++)
      if (cmask[i]) begin
        occ_d[head_q + IDW'(i)]  = 1'b0;
        done_d[head_q + IDW'(i)] = 1'b0;
      end
    if (disp_fire) begin
      tail_d  = tail_q + IDW'(ndisp);
      count_d = count_q + (IDW+1)'(ndisp) - (IDW+1)'(ncommit);
      for (int i = 0; i < SS; i++)
        if (disp_valid[i]) begin
          occ_d[disp_rob_id[i]]  = 1'b1;
          done_d[disp_rob_id[i]] = 1'b0;
        end
    end
`ifdef ROB_FLUSH_EN
    if (flush_fire) begin
      tail_d  = flush_rob_id + IDW'(1);
      count_d = (IDW+1)'(fage) + (IDW+1)'(1) - (IDW+1)'(ncommit);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      order_q <= '0;
      occ_q   <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      order_q <= order_d;
      occ_q   <= occ_d;
      done_q  <= done_d;
    end
  end

  // Payload needs no reset; lowest CDB port is written last so it wins.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SS; i++)
      if (disp_fire && disp_valid[i])
        ent_q[disp_rob_id[i]] <= disp_entry[i];
    for (int j = N_CDB - 1; j >= 0; j--)
      if (cdb_valid[j] && occ_q[cdb_rob_id[j]])
        ent_q[cdb_rob_id[j]].result <= cdb_result[j];
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (DEPTH=16, SS=2, CW=2, N_CDB=3).
`timescale 1ns/1ps
module tb_reorder_buffer;
  import rv32i_types::*;

  localparam int SS    = 2;
  localparam int CW    = 2;
  localparam int DEPTH = 16;
  localparam int N_CDB = 3;
  localparam int IDW   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [SS-1:0]    disp_valid;
  rob_entry_t       disp_entry   [SS];
  logic             disp_ready;
  logic [IDW-1:0]   disp_rob_id  [SS];
  logic [N_CDB-1:0] cdb_valid;
  logic [IDW-1:0]   cdb_rob_id   [N_CDB];
  logic [31:0]      cdb_result   [N_CDB];
  logic [CW-1:0]    commit_valid;
  rob_entry_t       commit_entry [CW];
  logic [63:0]      commit_order [CW];
  logic             flush_valid;
  logic [IDW-1:0]   flush_rob_id;
  logic [IDW:0]     count;

  int checks   = 0;
  int failures = 0;

  reorder_buffer #(
    .SS(SS), .CW(CW), .DEPTH(DEPTH), .N_CDB(N_CDB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .disp_valid   (disp_valid),
    .disp_entry   (disp_entry),
    .disp_ready   (disp_ready),
    .disp_rob_id  (disp_rob_id),
    .cdb_valid    (cdb_valid),
    .cdb_rob_id   (cdb_rob_id),
    .cdb_result   (cdb_result),
    .commit_valid (commit_valid),
    .commit_entry (commit_entry),
    .commit_order (commit_order),
    .flush_valid  (flush_valid),
    .flush_rob_id (flush_rob_id),
    .count        (count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic rob_entry_t mk(input logic [31:0] pc);
    rob_entry_t e;
    e        = '0;
    e.pc     = pc;
    e.rd     = pc[4:0];
    e.rd_we  = 1'b1;
    e.rvfi.insn = 32'h13;
    return e;
  endfunction

  task automatic disp(input logic [SS-1:0] v);
    disp_valid    = v;
    disp_entry[0] = mk(32'h1000);
    disp_entry[1] = mk(32'h1004);
    step();
    disp_valid = '0;
  endtask

  task automatic complete_range(input int start, input int n);
    for (int k = 0; k < n; k += N_CDB) begin
      for (int j = 0; j < N_CDB; j++) begin
        cdb_valid[j]  = (k + j < n);
        cdb_rob_id[j] = IDW'(start + k + j);
        cdb_result[j] = 32'(start + k + j);
      end
      step();
    end
    cdb_valid = '0;
  endtask

  task automatic wait_empty(input string tag);
    int c = 0;
    while (count !== '0 && c < 40) begin
      step();
      c++;
    end
    chk(tag, 64'(count), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    disp_valid   = '0;
    cdb_valid    = '0;
    flush_valid  = 1'b0;
    flush_rob_id = '0;
    for (int i = 0; i < SS; i++) disp_entry[i] = '0;
    for (int j = 0; j < N_CDB; j++) begin
      cdb_rob_id[j] = '0;
      cdb_result[j] = '0;
    end
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(disp_ready), 64'd1);
    chk("rst_id0", 64'(disp_rob_id[0]), 64'd0);
    chk("rst_id1", 64'(disp_rob_id[1]), 64'd1);
    chk("rst_cv", 64'(commit_valid), 64'd0);

    disp(2'b11);
    chk("d2_count", 64'(count), 64'd2);
    chk("d2_cv", 64'(commit_valid), 64'd0);
    chk("d2_tail", 64'(disp_rob_id[0]), 64'd2);

    cdb_valid[0] = 1'b1; cdb_rob_id[0] = 4'd1; cdb_result[0] = 32'h11;
    step();
    cdb_valid = '0;
    chk("ooo_nocommit", 64'(commit_valid), 64'd0);

    cdb_valid[0] = 1'b1; cdb_rob_id[0] = 4'd0; cdb_result[0] = 32'h10;
    step();
    cdb_valid = '0;
    chk("inord_cv", 64'(commit_valid), 64'd3);
    chk("inord_ord0", commit_order[0], 64'd0);
    chk("inord_ord1", commit_order[1], 64'd1);
    chk("inord_res0", 64'(commit_entry[0].result), 64'h10);
    chk("inord_res1", 64'(commit_entry[1].result), 64'h11);
    chk("inord_pc1", 64'(commit_entry[1].pc), 64'h1004);
    chk("inord_count", 64'(count), 64'd2);
    step();
    chk("drain1_count", 64'(count), 64'd0);
    chk("drain1_cv", 64'(commit_valid), 64'd0);

    disp(2'b11);
    disp(2'b11);
    chk("d4_count", 64'(count), 64'd4);
    complete_range(2, 2);
    chk("c23_cv", 64'(commit_valid), 64'd3);
    cdb_valid     = 3'b111;
    cdb_rob_id[0] = 4'd4; cdb_result[0] = 32'hA;
    cdb_rob_id[1] = 4'd4; cdb_result[1] = 32'hB;
    cdb_rob_id[2] = 4'd9; cdb_result[2] = 32'hC;
    step();
    cdb_valid = '0;
    chk("dual_cv", 64'(commit_valid), 64'd1);
    chk("dual_res", 64'(commit_entry[0].result), 64'hA);
    chk("dual_ord", commit_order[0], 64'd4);
    chk("dual_count", 64'(count), 64'd2);
    chk("unocc_done", 64'(dut.done_q[9]), 64'd0);
    complete_range(5, 1);
    chk("id5_cv", 64'(commit_valid), 64'd1);
    chk("id5_count", 64'(count), 64'd1);
    step();
    chk("drain2_count", 64'(count), 64'd0);

    for (int i = 0; i < 7; i++) disp(2'b11);
    chk("fill14_count", 64'(count), 64'd14);
    chk("fill14_ready", 64'(disp_ready), 64'd1);
    disp(2'b01);
    chk("fill15_count", 64'(count), 64'd15);
    chk("fill15_ready", 64'(disp_ready), 64'd0);
    disp(2'b11);
    chk("full_hold_count", 64'(count), 64'd15);
    chk("full_hold_tail", 64'(disp_rob_id[0]), 64'd5);
    complete_range(6, 1);
    chk("c6_cv", 64'(commit_valid), 64'd1);
    chk("c6_ready_same", 64'(disp_ready), 64'd0);
    step();
    chk("c6_ready_next", 64'(disp_ready), 64'd1);
    chk("c6_count", 64'(count), 64'd14);

    complete_range(7, 14);
    wait_empty("drain3_count");
    for (int i = 0; i < 4; i++) disp(2'b11);
    disp(2'b01);
    complete_range(5, 9);
    wait_empty("drain4_count");
    chk("wrap_tail", 64'(disp_rob_id[0]), 64'd14);
    disp(2'b11);
    chk("wrap_id0", 64'(disp_rob_id[0]), 64'd0);
    chk("wrap_id1", 64'(disp_rob_id[1]), 64'd1);
    disp(2'b11);
    chk("wrap_count4", 64'(count), 64'd4);
    complete_range(14, 2);
    chk("wrap_cv", 64'(commit_valid), 64'd3);
    chk("wrap_ord0", commit_order[0], 64'd30);
    chk("wrap_ord1", commit_order[1], 64'd31);
    chk("same_id0", 64'(disp_rob_id[0]), 64'd2);
    chk("same_id1", 64'(disp_rob_id[1]), 64'd3);
    disp(2'b11);
    chk("same_count", 64'(count), 64'd4);
    chk("same_head", 64'(dut.head_q), 64'd0);
    chk("same_tail", 64'(disp_rob_id[0]), 64'd4);
    chk("same_cv", 64'(commit_valid), 64'd0);

    disp_valid    = 2'b11;
    cdb_valid[0]  = 1'b1;
    cdb_rob_id[0] = 4'd0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_cv", 64'(commit_valid), 64'd0);
    chk("arst_ready", 64'(disp_ready), 64'd1);
    step();
    disp_valid = '0;
    cdb_valid  = '0;
    rst        = 1'b0;
    step();
    chk("post_rst_id0", 64'(disp_rob_id[0]), 64'd0);
    disp(2'b11);
    chk("post_rst_count", 64'(count), 64'd2);

`ifdef ROB_FLUSH_EN
    disp(2'b01);
    complete_range(0, 3);
    wait_empty("fl_drain");
    for (int i = 0; i < 3; i++) disp(2'b11);
    disp(2'b01);
    chk("fl_pre_count", 64'(count), 64'd7);
    flush_valid  = 1'b1;
    flush_rob_id = 4'd5;
    disp_valid   = 2'b11;
    step();
    flush_valid = 1'b0;
    disp_valid  = '0;
    chk("fl_count", 64'(count), 64'd3);
    chk("fl_tail", 64'(disp_rob_id[0]), 64'd6);
    complete_range(7, 1);
    chk("fl_id7_done", 64'(dut.done_q[7]), 64'd0);
    chk("fl_cv", 64'(commit_valid), 64'd0);
    chk("fl_count2", 64'(count), 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
